// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file with write-through bypass and write statistics
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         asynchronous, active-high; clears storage and statistics
//   RegWrite      write enable for the current cycle
//   wr_addr       destination register index
//   wr_data       write-back data
//   rs_addr       read port A index       -> rs_data (combinational, bypassed)
//   rt_addr       read port B index       -> rt_data (combinational, bypassed)
//   dbg_addr      debug read index        -> dbg_data (stored contents only)
//   wr_count      saturating count of committed writes
//   last_wr_addr  index of the most recent committed write

module reg_file #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count,
  output logic [4:0]        last_wr_addr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Entry 0 exists only so that every 5-bit index is in range; it is
  // cleared by reset, never written, and masked on every read port.
  logic [DATA_W-1:0] regs [0:31];

  logic commit;

  assign commit = RegWrite && (wr_addr != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      wr_count     <= '0;
      last_wr_addr <= '0;
    end else if (commit) begin
      regs[wr_addr] <= wr_data;
      last_wr_addr  <= wr_addr;
      if (wr_count != CNT_MAX) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // Bypass is gated by reset as well, so a write held on the inputs while
  // reset is asserted is never visible on the read ports.
  always_comb begin
    rs_data  = '0;
    rt_data  = '0;
    dbg_data = '0;
    if (!reset) begin
      if (rs_addr != 5'd0) begin
        rs_data = (commit && (wr_addr == rs_addr)) ? wr_data : regs[rs_addr];
      end
      if (rt_addr != 5'd0) begin
        rt_data = (commit && (wr_addr == rt_addr)) ? wr_data : regs[rt_addr];
      end
      if (dbg_addr != 5'd0) begin
        dbg_data = regs[dbg_addr];
      end
    end
  end

endmodule
